// File: rtl/bsg_cache_nb_to_test_dram_pkg.sv
// Shared types and parameter-derivation helpers for the test-DRAM read scheduler.
package bsg_cache_nb_to_test_dram_pkg;

  typedef enum logic {IDLE, SEND} tx_state_e;

  // A single-entry field still gets one bit so that packed concatenations stay legal.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  function automatic int bsg_width(input int x);
    return $clog2(x + 1);
  endfunction

  function automatic int num_req(input int words, input int word_width, input int dram_width);
    return words * word_width / dram_width;
  endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: combinational grant from the pointer; pointer moves past the
// winner only when the grant is actually taken (yumi).
module bsg_arb_round_robin
  import bsg_cache_nb_to_test_dram_pkg::*;
#(
  parameter int width_p     = 4,
  parameter int lg_width_lp = safe_clog2(width_p)
) (
  input  logic                   core_clk,
  input  logic                   core_reset,
  input  logic [width_p-1:0]     reqs,
  input  logic                   yumi,
  output logic [width_p-1:0]     grants,
  output logic [lg_width_lp-1:0] grant_id
);

  logic [lg_width_lp-1:0] ptr_r;
  logic                   found;
  int                     idx;

  always_comb begin
    grants   = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < width_p; i++) begin
      idx = (int'(ptr_r) + i) % width_p;
      if (!found && reqs[idx]) begin
        found       = 1'b1;
        grants[idx] = 1'b1;
        grant_id    = lg_width_lp'(idx);
      end
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_reset)
      ptr_r <= '0;
    else if (yumi)
      ptr_r <= (grant_id == lg_width_lp'(width_p - 1)) ? '0 : grant_id + 1'b1;
  end

endmodule

// File: rtl/bsg_cache_nb_to_test_dram_tx_sched_beat_gen.sv
// Beat counter for one block burst; offset is the byte displacement of the current beat.
// Advances only on an accepted beat, so it holds steady under backpressure.
module bsg_cache_nb_to_test_dram_tx_sched_beat_gen
  import bsg_cache_nb_to_test_dram_pkg::*;
#(
  parameter int num_req_p     = 2,
  parameter int beat_bytes_p  = 16,
  parameter int addr_width_p  = 28,
  parameter int lg_num_req_lp = safe_clog2(num_req_p)
) (
  input  logic                    core_clk,
  input  logic                    core_reset,
  input  logic                    advance,
  output logic                    last,
  output logic [addr_width_p-1:0] offset
);

  logic [lg_num_req_lp-1:0] beat_r;

  assign last   = (beat_r == lg_num_req_lp'(num_req_p - 1));
  assign offset = addr_width_p'(beat_r) * addr_width_p'(beat_bytes_p);

  always_ff @(posedge core_clk) begin
    if (core_reset)
      beat_r <= '0;
    else if (advance)
      beat_r <= last ? '0 : beat_r + 1'b1;
  end

endmodule

// File: rtl/bsg_counter_up_down.sv
// Up/down counter with multi-step increments and decrements applied in the same cycle.
module bsg_counter_up_down
  import bsg_cache_nb_to_test_dram_pkg::*;
#(
  parameter int max_val_p     = 8,
  parameter int init_val_p    = 0,
  parameter int max_step_p    = 4,
  parameter int width_lp      = bsg_width(max_val_p),
  parameter int step_width_lp = bsg_width(max_step_p)
) (
  input  logic                     core_clk,
  input  logic                     core_reset,
  input  logic [step_width_lp-1:0] up,
  input  logic [step_width_lp-1:0] down,
  output logic [width_lp-1:0]      count
);

  always_ff @(posedge core_clk) begin
    if (core_reset)
      count <= width_lp'(init_val_p);
    else
      count <= count + width_lp'(up) - width_lp'(down);
  end

endmodule

// File: rtl/bsg_cache_nb_to_test_dram_tx_sched.sv
// Arbitrates block reads from the caches, splits each into DRAM-width beats, and
// throttles grants with block credits returned by the read-return path.
module bsg_cache_nb_to_test_dram_tx_sched
  import bsg_cache_nb_to_test_dram_pkg::*;
#(
  parameter int num_cache_p                = 4,
  parameter int mshr_els_p                 = 4,
  parameter int data_width_p               = 32,
  parameter int block_size_in_words_p      = 8,
  parameter int dram_data_width_p          = 128,
  parameter int cache_addr_width_p         = 28,
  parameter int max_blocks_p               = 8,
  parameter int lg_num_cache_lp            = safe_clog2(num_cache_p),
  parameter int lg_mshr_els_lp             = safe_clog2(mshr_els_p),
  parameter int num_req_lp                 = num_req(block_size_in_words_p, data_width_p, dram_data_width_p),
  parameter int dram_channel_addr_width_lp = lg_num_cache_lp + cache_addr_width_p,
  parameter int credit_width_lp            = bsg_width(max_blocks_p)
) (
  input  logic                                            core_clk_i,
  input  logic                                            core_reset_i,
  input  logic [num_cache_p-1:0]                          dma_pkt_v_i,
  input  logic [num_cache_p-1:0][cache_addr_width_p-1:0] dma_pkt_addr_i,
  input  logic [num_cache_p-1:0][lg_mshr_els_lp-1:0]     dma_pkt_mshr_id_i,
  output logic [num_cache_p-1:0]                          dma_pkt_yumi_o,
  output logic                                            dram_req_v_o,
  output logic [dram_channel_addr_width_lp-1:0]          dram_req_ch_addr_o,
  output logic [lg_mshr_els_lp-1:0]                      dram_req_mshr_id_o,
  input  logic                                            dram_req_ready_i,
  input  logic [num_cache_p-1:0]                          block_done_i,
  output logic [credit_width_lp-1:0]                     credits_o,
  output logic                                            idle_o
);

  localparam int lg_block_bytes_lp = safe_clog2(block_size_in_words_p * data_width_p / 8);
  localparam int beat_bytes_lp     = dram_data_width_p / 8;
  localparam int done_width_lp     = bsg_width(num_cache_p);

  typedef struct packed {
    logic [dram_channel_addr_width_lp-1:0] ch_addr;
    logic [lg_mshr_els_lp-1:0]             mshr_id;
  } dram_req_s;

  tx_state_e                     state_r;
  logic [lg_num_cache_lp-1:0]    cache_id_r;
  logic [cache_addr_width_p-1:0] addr_r;
  logic [lg_mshr_els_lp-1:0]     mshr_id_r;

  logic [num_cache_p-1:0]        grants;
  logic [lg_num_cache_lp-1:0]    win_id;
  logic [cache_addr_width_p-1:0] win_addr;
  logic [credit_width_lp-1:0]    used_r;
  logic [done_width_lp-1:0]      done_cnt;
  logic [cache_addr_width_p-1:0] offset;
  logic                          grant;
  logic                          send_fire;
  logic                          last_beat;
  dram_req_s                     req;

  assign done_cnt  = done_width_lp'($countones(block_done_i));
  assign credits_o = credit_width_lp'(max_blocks_p) - used_r;
  assign grant     = (state_r == IDLE) && (credits_o != '0) && (|dma_pkt_v_i);
  assign send_fire = dram_req_v_o & dram_req_ready_i;
  assign win_addr  = dma_pkt_addr_i[win_id];

  assign dma_pkt_yumi_o = grant ? grants : '0;
  assign dram_req_v_o   = (state_r == SEND);
  assign idle_o         = (state_r == IDLE) && (used_r == '0);

  assign req.ch_addr         = {cache_id_r, addr_r + offset};
  assign req.mshr_id         = mshr_id_r;
  assign dram_req_ch_addr_o  = req.ch_addr;
  assign dram_req_mshr_id_o  = req.mshr_id;

  bsg_arb_round_robin #(
    .width_p(num_cache_p)
  ) arb (
    .core_clk  (core_clk_i),
    .core_reset(core_reset_i),
    .reqs      (dma_pkt_v_i),
    .yumi      (grant),
    .grants    (grants),
    .grant_id  (win_id)
  );

  // Counts blocks in flight; free credits are the complement against max_blocks_p.
  bsg_counter_up_down #(
    .max_val_p (max_blocks_p),
    .init_val_p(0),
    .max_step_p(num_cache_p)
  ) credit_ctr (
    .core_clk  (core_clk_i),
    .core_reset(core_reset_i),
    .up        (done_width_lp'(grant)),
    .down      (done_cnt),
    .count     (used_r)
  );

  bsg_cache_nb_to_test_dram_tx_sched_beat_gen #(
    .num_req_p   (num_req_lp),
    .beat_bytes_p(beat_bytes_lp),
    .addr_width_p(cache_addr_width_p)
  ) beat_gen (
    .core_clk  (core_clk_i),
    .core_reset(core_reset_i),
    .advance   (send_fire),
    .last      (last_beat),
    .offset    (offset)
  );

  // Returning to IDLE after the last beat gives the required bubble between blocks.
  always_ff @(posedge core_clk_i) begin
    if (core_reset_i) begin
      state_r    <= IDLE;
      cache_id_r <= '0;
      addr_r     <= '0;
      mshr_id_r  <= '0;
    end else begin
      case (state_r)
        IDLE: if (grant) begin
          cache_id_r <= win_id;
          addr_r     <= {win_addr[cache_addr_width_p-1:lg_block_bytes_lp], {lg_block_bytes_lp{1'b0}}};
          mshr_id_r  <= dma_pkt_mshr_id_i[win_id];
          state_r    <= SEND;
        end
        SEND: if (send_fire && last_beat) state_r <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge core_clk_i) begin
    if (!core_reset_i) begin
      assert ($onehot0(dma_pkt_yumi_o)) else $fatal(1, "yumi is not one-hot-or-zero");
      assert ((dma_pkt_yumi_o & ~dma_pkt_v_i) == '0) else $fatal(1, "yumi to an invalid requester");
      assert ((credit_width_lp+1)'(used_r) + (credit_width_lp+1)'(grant) >= (credit_width_lp+1)'(done_cnt))
        else $fatal(1, "block credits returned beyond max_blocks_p");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_cache_nb_to_test_dram_tx_sched.sv
// Randomized bench: transaction-level reference model feeds a beat scoreboard.
module tb_bsg_cache_nb_to_test_dram_tx_sched;

  localparam int N      = 4;
  localparam int MAX    = 8;
  localparam int NREQ   = 2;
  localparam int BEATB  = 16;

  typedef struct packed {
    logic [29:0] a;
    logic [1:0]  m;
  } beat_t;

  logic              core_clk_i = 1'b0;
  logic              core_reset_i;
  logic [N-1:0]      dma_pkt_v_i;
  logic [N-1:0][27:0] dma_pkt_addr_i;
  logic [N-1:0][1:0] dma_pkt_mshr_id_i;
  logic [N-1:0]      dma_pkt_yumi_o;
  logic              dram_req_v_o;
  logic [29:0]       dram_req_ch_addr_o;
  logic [1:0]        dram_req_mshr_id_o;
  logic              dram_req_ready_i;
  logic [N-1:0]      block_done_i;
  logic [3:0]        credits_o;
  logic              idle_o;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     m_ptr, m_busy, m_credits;
  beat_t  exp_q[$];
  logic [N-1:0] yumi_smp;

  bsg_cache_nb_to_test_dram_tx_sched dut (
    .core_clk_i        (core_clk_i),
    .core_reset_i      (core_reset_i),
    .dma_pkt_v_i       (dma_pkt_v_i),
    .dma_pkt_addr_i    (dma_pkt_addr_i),
    .dma_pkt_mshr_id_i (dma_pkt_mshr_id_i),
    .dma_pkt_yumi_o    (dma_pkt_yumi_o),
    .dram_req_v_o      (dram_req_v_o),
    .dram_req_ch_addr_o(dram_req_ch_addr_o),
    .dram_req_mshr_id_o(dram_req_mshr_id_o),
    .dram_req_ready_i  (dram_req_ready_i),
    .block_done_i      (block_done_i),
    .credits_o         (credits_o),
    .idle_o            (idle_o)
  );

  always #5 core_clk_i = ~core_clk_i;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: evaluated once per cycle on the inputs the next edge will sample.
  always @(negedge core_clk_i) begin : model
    int          w;
    logic [27:0] base;
    logic [N-1:0] exp_yumi;
    yumi_smp = dma_pkt_yumi_o;
    if (core_reset_i) begin
      m_ptr = 0; m_busy = 0; m_credits = MAX;
      exp_q.delete();
    end else begin
      w = -1;
      if (m_busy == 0 && m_credits > 0)
        for (int k = 0; k < N; k++)
          if (w < 0 && dma_pkt_v_i[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      exp_yumi = (w >= 0) ? N'(1 << w) : '0;
      check("yumi", 64'(dma_pkt_yumi_o), 64'(exp_yumi));
      check("req_v", 64'(dram_req_v_o), 64'(m_busy > 0));
      check("credits", 64'(credits_o), 64'(m_credits));
      check("idle", 64'(idle_o), 64'(m_busy == 0 && m_credits == MAX));
      if (m_busy > 0 && dram_req_ready_i) m_busy--;
      if (w >= 0) begin
        base = dma_pkt_addr_i[w] & ~28'h1f;
        for (int b = 0; b < NREQ; b++)
          exp_q.push_back('{a: {2'(w), base + 28'(b * BEATB)}, m: dma_pkt_mshr_id_i[w]});
        m_ptr = (w + 1) % N;
        m_busy = NREQ;
        m_credits--;
      end
      m_credits += $countones(block_done_i);
    end
  end

  // Scoreboard monitor for DRAM beats.
  always @(negedge core_clk_i) begin
    if (!core_reset_i && dram_req_v_o) begin
      check("beat_pending", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        check("ch_addr", 64'(dram_req_ch_addr_o), 64'(exp_q[0].a));
        check("mshr_id", 64'(dram_req_mshr_id_o), 64'(exp_q[0].m));
        if (dram_req_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive_cycle(input int vp, input int rp, input int dp);
    int cnt;
    @(posedge core_clk_i); #1;
    for (int i = 0; i < N; i++) begin
      if (yumi_smp[i]) dma_pkt_v_i[i] = 1'b0;
      if (!dma_pkt_v_i[i] && int'($urandom % 100) < vp) begin
        dma_pkt_v_i[i]       = 1'b1;
        dma_pkt_addr_i[i]    = 28'($urandom);
        dma_pkt_mshr_id_i[i] = 2'($urandom);
      end
    end
    dram_req_ready_i = int'($urandom % 100) < rp;
    cnt = 0;
    block_done_i = '0;
    for (int i = 0; i < N; i++)
      if (cnt < MAX - m_credits && int'($urandom % 100) < dp) begin
        block_done_i[i] = 1'b1;
        cnt++;
      end
  endtask

  initial begin : stim
    logic found;
    core_reset_i = 1'b1;
    dma_pkt_v_i = '0; dma_pkt_addr_i = '0; dma_pkt_mshr_id_i = '0;
    dram_req_ready_i = 1'b0; block_done_i = '0;
    repeat (3) @(posedge core_clk_i);
    #1 core_reset_i = 1'b0;
    @(negedge core_clk_i);
    check("rst_credits", 64'(credits_o), 64'(8));
    check("rst_idle", 64'(idle_o), 64'(1));
    check("rst_v", 64'(dram_req_v_o), 64'(0));

    // Single read from cache 2.
    @(posedge core_clk_i); #1;
    dma_pkt_v_i = 4'b0100; dma_pkt_addr_i[2] = 28'h0000104; dma_pkt_mshr_id_i[2] = 2'd3;
    dram_req_ready_i = 1'b1;
    @(negedge core_clk_i);
    check("sr_yumi", 64'(dma_pkt_yumi_o), 64'(4'b0100));
    @(posedge core_clk_i); #1 dma_pkt_v_i = '0;
    @(negedge core_clk_i);
    check("sr_beat0", 64'(dram_req_ch_addr_o), 64'({2'd2, 28'h0000100}));
    check("sr_mshr", 64'(dram_req_mshr_id_o), 64'(3));
    check("sr_credits", 64'(credits_o), 64'(7));
    @(negedge core_clk_i);
    check("sr_beat1", 64'(dram_req_ch_addr_o), 64'({2'd2, 28'h0000110}));
    @(negedge core_clk_i);
    check("sr_bubble", 64'(dram_req_v_o), 64'(0));

    repeat (300) drive_cycle(60, 70, 30);
    repeat (40)  drive_cycle(100, 100, 50);

    // Credit exhaustion and recovery.
    repeat (40) drive_cycle(100, 100, 0);
    @(negedge core_clk_i);
    check("exh_credits", 64'(credits_o), 64'(0));
    check("exh_stall", 64'(dma_pkt_yumi_o), 64'(0));
    @(posedge core_clk_i); #1 block_done_i = 4'b0101;
    @(posedge core_clk_i); #1 block_done_i = '0;
    @(negedge core_clk_i);
    check("exh_return", 64'(credits_o), 64'(2));
    check("exh_resume", 64'(dma_pkt_yumi_o != '0), 64'(1));

    repeat (200) drive_cycle(70, 30, 30);

    // Reset during beat 0 of a burst.
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      drive_cycle(100, 100, 0);
      @(negedge core_clk_i);
      if (dma_pkt_yumi_o != '0) found = 1'b1;
    end
    check("rst_grant_seen", 64'(found), 64'(1));
    @(posedge core_clk_i); #1;
    for (int i = 0; i < N; i++) if (yumi_smp[i]) dma_pkt_v_i[i] = 1'b0;
    dram_req_ready_i = 1'b0; block_done_i = '0; core_reset_i = 1'b1;
    @(negedge core_clk_i);
    check("mid_beat0_v", 64'(dram_req_v_o), 64'(1));
    @(posedge core_clk_i); #1 core_reset_i = 1'b0;
    @(negedge core_clk_i);
    check("mid_rst_v", 64'(dram_req_v_o), 64'(0));
    check("mid_rst_credits", 64'(credits_o), 64'(8));
    check("mid_rst_idle", 64'(idle_o), 64'(1));

    repeat (200) drive_cycle(50, 80, 40);
    repeat (10)  drive_cycle(0, 100, 0);
    @(negedge core_clk_i);
    check("drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_cache_nb_to_test_dram_tx_sched.md
Name: bsg_cache_nb_to_test_dram_tx_sched

Overview:
- Read-request scheduler in front of the test-DRAM channel for the non-blocking cache array.
- Round-robin arbitrates block-read DMA requests from num_cache_p caches, each tagged with an MSHR id.
- Splits each granted block into num_req_lp DRAM-width requests carrying channel address and MSHR id.
- Throttles issue with a block-credit counter so the return path's CDC FIFOs can never overflow; credits come back when the return path finishes delivering a block to its cache.

Parameters:
- num_cache_p, 4, number of requesting caches
- mshr_els_p, 4, MSHR entries per cache
- data_width_p, 32, cache word width in bits
- block_size_in_words_p, 8, words per cache block
- dram_data_width_p, 128, DRAM request data width in bits
- cache_addr_width_p, 28, byte address width per cache
- max_blocks_p, 8, outstanding block-read credits
- derived: lg_num_cache_lp = SAFE_CLOG2(num_cache_p)
- derived: lg_mshr_els_lp = SAFE_CLOG2(mshr_els_p)
- derived: num_req_lp = block_size_in_words_p*data_width_p/dram_data_width_p
- derived: dram_channel_addr_width_lp = lg_num_cache_lp + cache_addr_width_p

Ports:
- core_clk_i  in  1  clock
- core_reset_i  in  1  synchronous active-high reset
- dma_pkt_v_i  in  num_cache_p  read request valid, per cache
- dma_pkt_addr_i  in  num_cache_p x cache_addr_width_p  block byte address
- dma_pkt_mshr_id_i  in  num_cache_p x lg_mshr_els_lp  requesting MSHR
- dma_pkt_yumi_o  out  num_cache_p  request consumed (one-hot or zero)
- dram_req_v_o  out  1  DRAM request valid
- dram_req_ch_addr_o  out  dram_channel_addr_width_lp  {cache_id, byte addr}
- dram_req_mshr_id_o  out  lg_mshr_els_lp  MSHR tag
- dram_req_ready_i  in  1  DRAM side accepts request
- block_done_i  in  num_cache_p  one-cycle pulse per block fully returned to cache
- credits_o  out  BSG_WIDTH(max_blocks_p)  free credits
- idle_o  out  1  IDLE state and credits_o == max_blocks_p

Behaviour:
- Single clock domain; all state reset synchronously.
- Reset values:
  - FSM IDLE, credits = max_blocks_p, rr pointer 0, beat = 0.
  - Outputs dram_req_v_o=0, dma_pkt_yumi_o=0, idle_o=1.
  - Reset mid-burst abandons the remaining beats; no partial recovery.
- FSM, state IDLE:
  - Grant when credits > 0 and |dma_pkt_v_i.
  - Winner is the first valid cache at or after the rr pointer, wrapping.
  - Same cycle: dma_pkt_yumi_o[winner]=1; latch cache_id, addr with low SAFE_CLOG2(block bytes) bits zeroed, and mshr_id; credit consumed; pointer <= winner+1 mod num_cache_p; go to SEND.
  - No grant: yumi all zero, pointer held.
- FSM, state SEND:
  - dram_req_v_o=1.
  - ch_addr = {cache_id_r, addr_r + beat*(dram_data_width_p/8)}; mshr_id = mshr_id_r.
  - Beat advances on dram_req_v_o & dram_req_ready_i.
  - Accepting beat num_req_lp-1 -> beat=0, go to IDLE. One-cycle bubble between blocks is required.
  - Outputs held stable while ready is low; v never drops mid-block.
- Latency: request valid in IDLE with credit -> yumi same cycle -> first dram_req_v_o next cycle.
- Credits:
  - credits_n = credits_r - grant + popcount(block_done_i).
  - Simultaneous grant and returns are netted in one cycle.
  - Returns arriving while credits == 0 unblock grant on the following cycle.
  - Exceeding max_blocks_p is illegal; simulation-only assertion fatal.
- Other simulation assertions: yumi one-hot-or-zero; no yumi to an invalid requester.
- num_cache_p==1: cache_id field is the 1-bit constant 0 under SAFE_CLOG2 (so dram_channel_addr_width_lp = cache_addr_width_p+1); arbitration is trivial.
- num_req_lp==1: SEND lasts exactly one accepted beat.

Decomposition:
- Shared package bsg_cache_nb_to_test_dram_pkg: dram request struct {ch_addr, mshr_id}, FSM state enum {IDLE, SEND}, num_req_lp/lg derivation helpers.
- Reuse bsg_arb_round_robin for the cache select.
- Reuse bsg_counter_up_down for credits; its down input is driven with popcount(block_done_i).
- One natural sub-module: bsg_cache_nb_to_test_dram_tx_sched_beat_gen (beat counter plus address offset generation).

Test Plan:
- Single read: cache 2, addr 0x0000104, mshr 3, ready=1 -> yumi[2] at cycle 0; req ch_addr {2,0x0000100} cycle 1, {2,0x0000110} cycle 2, mshr 3; IDLE cycle 3; credits 8->7.
- Fairness: all 4 caches valid continuously, ready=1 -> grant order 0,1,2,3,0; each grant 3 cycles apart.
- Credit exhaustion: 8 grants, no block_done -> 9th request stalls with credits_o=0; block_done_i=4'b0101 -> credits 2 next cycle; grant resumes.
- Backpressure: ready low 5 cycles during beat 1 -> v, ch_addr, mshr held constant; burst completes after ready rises.
- Simultaneous grant and 2 returns with credits=3 -> credits 4.
- Reset asserted during beat 0 of SEND -> next cycle dram_req_v_o=0, credits 8, idle_o=1.
